// File: rtl/axis64to128_packer.sv
`timescale 1ns/1ps
// Packs 64-bit AXI-Stream beats into 128-bit words, first beat in the upper half; odd frames padded low.
// Latency: 1 cycle after the completing beat; s_axis_tready = ~m_axis_tvalid | m_axis_tready.
module axis64to128_packer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 rx_axis_uclk,
  input  logic                 RxAxis_Rstn,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [127:0]         m_axis_tdata,
  output logic [15:0]          m_axis_tkeep,
  output logic                 m_axis_tlast,
  input  logic                 CntClr,
  output logic [CNT_WIDTH-1:0] FrmIn_Cnt,
  output logic [CNT_WIDTH-1:0] FrmOut_Cnt,
  output logic [CNT_WIDTH-1:0] KeepErr_Cnt
);

  typedef enum logic {EMPTY, HALF} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t         state_q, state_d;
  logic [63:0]    hi_data_q, hi_data_d;
  logic [7:0]     hi_keep_q, hi_keep_d;
  logic           m_vld_q, m_vld_d;
  logic [127:0]   m_dat_q, m_dat_d;
  logic [15:0]    m_keep_q, m_keep_d;
  logic           m_last_q, m_last_d;
  logic [CNT_WIDTH-1:0] frm_in_q, frm_out_q, keep_err_q;

  logic s_fire;
  logic m_fire;
  logic keep_bad;
  logic load;

  assign s_axis_tready = ~m_vld_q | m_axis_tready;
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign m_fire        = m_vld_q & m_axis_tready;
  assign keep_bad      = s_axis_tlast ? (s_axis_tkeep == 8'h00) : (s_axis_tkeep != 8'hFF);

  always_comb begin
    state_d   = state_q;
    hi_data_d = hi_data_q;
    hi_keep_d = hi_keep_q;
    m_dat_d   = m_dat_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    load      = 1'b0;
    if (s_fire) begin
      case (state_q)
        EMPTY: begin
          if (s_axis_tlast) begin
            load     = 1'b1;
            m_dat_d  = {s_axis_tdata, 64'h0};
            m_keep_d = {s_axis_tkeep, 8'h00};
            m_last_d = 1'b1;
          end else begin
            hi_data_d = s_axis_tdata;
            hi_keep_d = 8'hFF;
            state_d   = HALF;
          end
        end
        HALF: begin
          load     = 1'b1;
          m_dat_d  = {hi_data_q, s_axis_tdata};
          m_keep_d = {hi_keep_q, s_axis_tlast ? s_axis_tkeep : 8'hFF};
          m_last_d = s_axis_tlast;
          state_d  = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
    // A load replaces an accepted word in the same cycle, giving back-to-back output.
    if (load) begin
      m_vld_d = 1'b1;
    end else if (m_axis_tready) begin
      m_vld_d = 1'b0;
    end else begin
      m_vld_d = m_vld_q;
    end
  end

  always_ff @(posedge rx_axis_uclk or negedge RxAxis_Rstn) begin
    if (!RxAxis_Rstn) begin
      state_q   <= EMPTY;
      hi_data_q <= '0;
      hi_keep_q <= '0;
      m_vld_q   <= 1'b0;
      m_dat_q   <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_data_q <= hi_data_d;
      hi_keep_q <= hi_keep_d;
      m_vld_q   <= m_vld_d;
      m_dat_q   <= m_dat_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge rx_axis_uclk or negedge RxAxis_Rstn) begin
    if (!RxAxis_Rstn) begin
      frm_in_q   <= '0;
      frm_out_q  <= '0;
      keep_err_q <= '0;
    end else if (CntClr) begin
      frm_in_q   <= '0;
      frm_out_q  <= '0;
      keep_err_q <= '0;
    end else begin
      if (s_fire && s_axis_tlast) frm_in_q   <= frm_in_q + CNT_ONE;
      if (m_fire && m_last_q)     frm_out_q  <= frm_out_q + CNT_ONE;
      if (s_fire && keep_bad)     keep_err_q <= keep_err_q + CNT_ONE;
    end
  end

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign FrmIn_Cnt     = frm_in_q;
  assign FrmOut_Cnt    = frm_out_q;
  assign KeepErr_Cnt   = keep_err_q;

endmodule

// File: tb/tb_axis64to128_packer.sv
`timescale 1ns/1ps
// Bench for axis64to128_packer: directed steps plus random frames against a frame-level packing model.
module tb_axis64to128_packer;

  logic         clk;
  logic         rstn;
  logic         s_tvalid, s_tready, s_tlast;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         cnt_clr;
  logic [31:0]  frm_in, frm_out, keep_err;

  axis64to128_packer #(.CNT_WIDTH(32)) dut (
    .rx_axis_uclk (clk),
    .RxAxis_Rstn  (rstn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .CntClr       (cnt_clr),
    .FrmIn_Cnt    (frm_in),
    .FrmOut_Cnt   (frm_out),
    .KeepErr_Cnt  (keep_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } word_t;

  word_t       exp_q[$];
  logic [63:0] fd[$];
  logic [7:0]  fk[$];
  int n_chk = 0;
  int n_fail = 0;
  int mdl_in = 0, mdl_out = 0, mdl_err = 0;
  int beat_no = 0;
  bit exp_vld_next = 0;
  bit fired = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic bit illegal(input logic [7:0] k, input logic last);
    return last ? (k == 8'h00) : (k != 8'hFF);
  endfunction

  // Expected words of the frame held in fd/fk: beats taken in pairs, an odd tail padded low.
  task automatic add_frame();
    word_t w;
    int n = fd.size();
    for (int i = 0; i < n; i += 2) begin
      if (i + 1 < n) begin
        w.d = {fd[i], fd[i+1]};
        w.k = {8'hFF, (i + 1 == n - 1) ? fk[i+1] : 8'hFF};
        w.l = (i + 1 == n - 1);
      end else begin
        w.d = {fd[i], 64'h0};
        w.k = {fk[i], 8'h00};
        w.l = 1'b1;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic set_ready();
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      default: m_tready = 1'b0;
    endcase
  endtask

  // One clock: observe at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle();
    word_t w;
    @(negedge clk);
    if (exp_vld_next) chk("latency_vld", m_tvalid, 1'b1);
    exp_vld_next = 0;
    chk("s_tready_rule", s_tready, !m_tvalid || m_tready);
    fired = s_tvalid && s_tready;
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", m_tvalid, 1'b0);
      end else begin
        w = exp_q.pop_front();
        chk("out_data", m_tdata, w.d);
        chk("out_keep", m_tkeep, w.k);
        chk("out_last", m_tlast, w.l);
        if (!cnt_clr && w.l) mdl_out++;
      end
    end
    if (cnt_clr) begin
      mdl_in = 0; mdl_out = 0; mdl_err = 0;
    end else if (fired) begin
      if (s_tlast) mdl_in++;
      if (illegal(s_tkeep, s_tlast)) mdl_err++;
    end
    if (fired) begin
      if ((beat_no % 2 == 1) || s_tlast) exp_vld_next = 1;
      beat_no = s_tlast ? 0 : beat_no + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
    if (rdy_mode == 1) begin
      repeat ($urandom_range(0, 2)) begin
        s_tvalid = 1'b0;
        set_ready();
        cycle();
      end
    end
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = last;
    fired = 0;
    for (int t = 0; t < 200 && !fired; t++) begin
      set_ready();
      cycle();
    end
    if (!fired) chk("beat_timeout", fired, 1'b1);
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame();
    add_frame();
    for (int i = 0; i < fd.size(); i++) send_beat(fd[i], fk[i], i == fd.size() - 1);
  endtask

  task automatic drain();
    rdy_mode = 0;
    s_tvalid = 1'b0;
    for (int t = 0; t < 50 && (exp_q.size() > 0 || m_tvalid); t++) begin
      set_ready();
      cycle();
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 128'h0);
    chk("rst_tkeep", m_tkeep, 16'h0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_cnt", {frm_in, frm_out, keep_err}, 96'h0);
    exp_q.delete();
    mdl_in = 0; mdl_out = 0; mdl_err = 0;
    beat_no = 0; exp_vld_next = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0;
    m_tready = 1'b1; cnt_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_tvalid", m_tvalid, 1'b0);
    chk("init_tdata", m_tdata, 128'h0);
    chk("init_tkeep", m_tkeep, 16'h0);
    chk("init_tready", s_tready, 1'b1);
    chk("init_cnt", {frm_in, frm_out, keep_err}, 96'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 4-beat full frame, sink always ready
    rdy_mode = 0;
    fd = '{64'hD0D0_0000_0000_00D0, 64'hD1D1_1111_1111_11D1, 64'hD2D2_2222_2222_22D2, 64'hD3D3_3333_3333_33D3};
    fk = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame();
    drain();
    chk("frm4_in", frm_in, 32'd1);
    chk("frm4_out", frm_out, 32'd1);

    // 3-beat frame, short last beat
    fd = '{64'hA0, 64'hA1, 64'hA2}; fk = '{8'hFF, 8'hFF, 8'h0F};
    send_frame();
    // single-beat frame, then a 2-beat frame must start in the upper half
    fd = '{64'hB0}; fk = '{8'h01};
    send_frame();
    fd = '{64'hC0, 64'hC1}; fk = '{8'hFF, 8'h3F};
    send_frame();
    drain();

    // backpressure: word pending, sink stalled 5 cycles
    rdy_mode = 2;
    fd = '{64'hE0, 64'hE1}; fk = '{8'hFF, 8'hFF};
    send_frame();
    fd = '{64'hE2}; fk = '{8'h0F};
    add_frame();
    s_tvalid = 1'b1; s_tdata = 64'hE2; s_tkeep = 8'h0F; s_tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_tready = 1'b0;
      cycle();
      chk("bp_tready", s_tready, 1'b0);
      chk("bp_tvalid", m_tvalid, 1'b1);
      chk("bp_tdata", m_tdata, exp_q[0].d);
      chk("bp_tkeep", m_tkeep, exp_q[0].k);
    end
    rdy_mode = 0;
    send_beat(64'hE2, 8'h0F, 1'b1);
    drain();

    // illegal keep on a non-last beat is sanitised and counted
    fd = '{64'hF0, 64'hF1}; fk = '{8'h7F, 8'hFF};
    send_frame();
    drain();
    chk("keeperr_one", keep_err, 32'd1);

    // clear in the same cycle as a tlast beat
    fd = '{64'h11}; fk = '{8'hFF};
    add_frame();
    cnt_clr = 1'b1;
    send_beat(64'h11, 8'hFF, 1'b1);
    cnt_clr = 1'b0;
    chk("clr_cnt", {frm_in, frm_out, keep_err}, 96'h0);
    drain();

    // last beat with empty keep is forwarded as keep 0 and counted
    fd = '{64'h21, 64'h22}; fk = '{8'hFF, 8'h00};
    send_frame();
    drain();
    chk("zero_keep_err", keep_err, mdl_err);

    // async reset with a word pending
    rdy_mode = 2;
    fd = '{64'h31}; fk = '{8'h03};
    send_frame();
    do_reset();
    // async reset while half a word is stored
    rdy_mode = 0;
    send_beat(64'h4141_4141_4141_4141, 8'hFF, 1'b0);
    do_reset();
    fd = '{64'h5151_5151_5151_5151, 64'h5252_5252_5252_5252}; fk = '{8'hFF, 8'hFF};
    send_frame();
    drain();

    // random frames with random backpressure, gaps and occasional bad keep
    for (int f = 0; f < 100; f++) begin
      int n;
      n = $urandom_range(1, 9);
      fd.delete(); fk.delete();
      for (int i = 0; i < n; i++) begin
        fd.push_back({$urandom, $urandom});
        if (i < n - 1) fk.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF);
        else if ($urandom_range(0, 15) == 0) fk.push_back(8'h00);
        else fk.push_back(8'($urandom_range(1, 255)));
      end
      rdy_mode = $urandom_range(0, 1);
      send_frame();
    end
    drain();
    chk("rand_frm_in", frm_in, mdl_in);
    chk("rand_frm_out", frm_out, mdl_out);
    chk("rand_keep_err", keep_err, mdl_err);
    chk("rand_in_eq_out", frm_in, frm_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
